// File: rtl/tick_prescaler_pkg.sv
// Shared constants and helpers for the tick prescaler and its cascade counters.
package tick_pkg;

  localparam int unsigned MIN_DIV        = 2;
  localparam int unsigned SEC_DIV_100MHZ = 100000000;
  localparam int unsigned CASC_MOD_60    = 60;
  localparam int unsigned CASC_MOD_24    = 24;

  // Number of bits needed to hold the values 0..n-1 (minimum 1).
  function automatic int unsigned width_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler_if.sv
// Control/status bundle of one tick_prescaler instance.
interface tick_prescaler_if #(
  parameter int unsigned DIV_W  = 27,
  parameter int unsigned CASC_W = 6
);
  logic              en;
  logic              clr;
  logic              div_wr;
  logic [DIV_W-1:0]  div_in;
  logic              div_pending;
  logic [DIV_W-1:0]  cur_div;
  logic              tick;
  logic              square;
  logic [CASC_W-1:0] casc_val;
  logic              casc_carry;

  modport master (
    output en, clr, div_wr, div_in,
    input  div_pending, cur_div, tick, square, casc_val, casc_carry
  );

  modport slave (
    input  en, clr, div_wr, div_in,
    output div_pending, cur_div, tick, square, casc_val, casc_carry
  );
endinterface

// File: rtl/tick_prescaler_mod_counter.sv
// Modulo-MOD counter with a one-cycle carry coincident with the wrap to 0.
module mod_counter import tick_pkg::*; #(
  parameter int unsigned MOD = CASC_MOD_60,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val,
  output logic         carry
);

  // Advance on inc, wrap at MOD-1 and flag the wrap in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val   <= '0;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (inc) begin
        if (val == W'(MOD - 1)) begin
          val   <= '0;
          carry <= 1'b1;
        end else begin
          val <= val + W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// Runtime-loadable clock prescaler: tick pulse, square wave and cascaded modulo count.
module tick_prescaler import tick_pkg::*; #(
  parameter int unsigned DIV_W            = 27,
  parameter int unsigned DEFAULT_DIV      = SEC_DIV_100MHZ,
  parameter bit          CLEAR_ON_DISABLE = 1'b1,
  parameter int unsigned CASC_MOD         = CASC_MOD_60,
  parameter int unsigned CASC_W           = 6
) (
  input  logic            clk,
  input  logic            rst,
  tick_prescaler_if.slave bus
);

  logic [DIV_W-1:0]  count;
  logic [DIV_W-1:0]  cur_div;
  logic [DIV_W-1:0]  staged;
  logic [DIV_W-1:0]  div_clamped;
  logic              pending;
  logic              tick;
  logic              square;
  logic              wrap;
  logic              apply;
  logic [CASC_W-1:0] casc_val;
  logic              casc_carry;

  // Wrap detection, staged-divisor apply condition and clamp of incoming divisor.
  // >= rather than == so a count held above a freshly loaded shorter divisor still wraps.
  always_comb begin
    wrap        = bus.en && !bus.clr && (count >= (cur_div - DIV_W'(1)));
    apply       = pending && (wrap || !bus.en || bus.clr);
    div_clamped = (bus.div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div_in;
  end

  // Prescale count, divisor staging/apply, and registered tick/square.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      cur_div <= DIV_W'(DEFAULT_DIV);
      staged  <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      tick    <= 1'b0;
      square  <= 1'b1;
    end else begin
      tick   <= wrap;
      square <= (count < (cur_div >> 1));

      if (bus.clr) begin
        count <= '0;
      end else if (!bus.en) begin
        if (CLEAR_ON_DISABLE) begin
          count <= '0;
        end
      end else if (wrap) begin
        count <= '0;
      end else begin
        count <= count + DIV_W'(1);
      end

      if (apply) begin
        cur_div <= staged;
        pending <= 1'b0;
      end
      // A strobe on an apply edge is kept staged for the following wrap.
      if (bus.div_wr) begin
        staged  <= div_clamped;
        pending <= 1'b1;
      end
    end
  end

  mod_counter #(
    .MOD (CASC_MOD),
    .W   (CASC_W)
  ) u_casc (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (wrap),
    .val   (casc_val),
    .carry (casc_carry)
  );

  assign bus.div_pending = pending;
  assign bus.cur_div     = cur_div;
  assign bus.tick        = tick;
  assign bus.square      = square;
  assign bus.casc_val    = casc_val;
  assign bus.casc_carry  = casc_carry;

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler: two instances differing only in disable mode.
module tb_tick_prescaler;

  localparam int DIV_W  = 8;
  localparam int CASC_W = 2;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             clr    = 1'b0;
  logic             div_wr = 1'b0;
  logic [DIV_W-1:0] div_in = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic              tick0;
    logic              tick1;
    logic              sq0;
    logic [CASC_W-1:0] casc;
    logic              carry;
    bit                full;
  } exp_t;

  exp_t sb[$];

  tick_prescaler_if #(.DIV_W(DIV_W), .CASC_W(CASC_W)) bus0 ();
  tick_prescaler_if #(.DIV_W(DIV_W), .CASC_W(CASC_W)) bus1 ();

  assign bus0.en = en;  assign bus0.clr = clr;  assign bus0.div_wr = div_wr;  assign bus0.div_in = div_in;
  assign bus1.en = en;  assign bus1.clr = clr;  assign bus1.div_wr = div_wr;  assign bus1.div_in = div_in;

  tick_prescaler #(
    .DIV_W(DIV_W), .DEFAULT_DIV(5), .CLEAR_ON_DISABLE(1'b1), .CASC_MOD(3), .CASC_W(CASC_W)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  tick_prescaler #(
    .DIV_W(DIV_W), .DEFAULT_DIV(5), .CLEAR_ON_DISABLE(1'b0), .CASC_MOD(3), .CASC_W(CASC_W)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; div_wr = 1'b0; div_in = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus0.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", bus0.tick); end
    total++; if (bus0.square !== 1'b1) begin bad++; $display("FAIL reset_square got=%0b exp=1", bus0.square); end
    total++; if (bus0.casc_val !== 2'd0) begin bad++; $display("FAIL reset_casc got=%0d exp=0", bus0.casc_val); end
    total++; if (bus0.casc_carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%0b exp=0", bus0.casc_carry); end
    total++; if (bus0.cur_div !== 8'd5) begin bad++; $display("FAIL reset_cur_div got=%0d exp=5", bus0.cur_div); end
    total++; if (bus0.div_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b exp=0", bus0.div_pending); end
  endtask

  task automatic test_period();
    exp_t e;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      e.tick0 = (k % 5 == 0); e.tick1 = (k % 5 == 0);
      e.sq0 = (((k - 1) % 5) < 2); e.casc = CASC_W'((k / 5) % 3); e.carry = (k == 15); e.full = 1'b1;
      sb.push_back(e);
    end
    for (int k = 1; k <= 15; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL period_tick0 cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      total++; if (bus1.tick !== e.tick1) begin bad++; $display("FAIL period_tick1 cyc=%0d got=%0b exp=%0b", k, bus1.tick, e.tick1); end
      total++; if (bus0.square !== e.sq0) begin bad++; $display("FAIL period_square cyc=%0d got=%0b exp=%0b", k, bus0.square, e.sq0); end
      if (e.full) begin
        total++; if (bus0.casc_val !== e.casc) begin bad++; $display("FAIL period_casc cyc=%0d got=%0d exp=%0d", k, bus0.casc_val, e.casc); end
        total++; if (bus0.casc_carry !== e.carry) begin bad++; $display("FAIL period_carry cyc=%0d got=%0b exp=%0b", k, bus0.casc_carry, e.carry); end
      end
    end
  endtask

  task automatic test_cascade();
    exp_t e;
    do_reset();
    div_in = 8'd4; div_wr = 1'b1;
    cyc();
    div_wr = 1'b0;
    cyc();
    total++; if (bus0.cur_div !== 8'd4) begin bad++; $display("FAIL casc_load_div got=%0d exp=4", bus0.cur_div); end
    total++; if (bus0.div_pending !== 1'b0) begin bad++; $display("FAIL casc_load_pending got=%0b exp=0", bus0.div_pending); end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      e.tick0 = (k % 4 == 0); e.tick1 = (k % 4 == 0);
      e.sq0 = (((k - 1) % 4) < 2); e.casc = CASC_W'((k / 4) % 3); e.carry = (k == 12); e.full = 1'b1;
      sb.push_back(e);
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL casc_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      total++; if (bus0.square !== e.sq0) begin bad++; $display("FAIL casc_square cyc=%0d got=%0b exp=%0b", k, bus0.square, e.sq0); end
      if (e.full) begin
        total++; if (bus0.casc_val !== e.casc) begin bad++; $display("FAIL casc_val cyc=%0d got=%0d exp=%0d", k, bus0.casc_val, e.casc); end
        total++; if (bus0.casc_carry !== e.carry) begin bad++; $display("FAIL casc_carry cyc=%0d got=%0b exp=%0b", k, bus0.casc_carry, e.carry); end
      end
    end
  endtask

  task automatic test_reload();
    exp_t e;
    do_reset();
    en = 1'b1;
    cyc();
    div_in = 8'd3; div_wr = 1'b1;
    cyc();
    div_wr = 1'b0;
    total++; if (bus0.div_pending !== 1'b1) begin bad++; $display("FAIL reload_pending got=%0b exp=1", bus0.div_pending); end
    total++; if (bus0.cur_div !== 8'd5) begin bad++; $display("FAIL reload_cur_div_before got=%0d exp=5", bus0.cur_div); end
    for (int k = 3; k <= 11; k++) begin
      e = '{tick0: (k == 5 || k == 8 || k == 11), tick1: 1'b0, sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      e.tick1 = e.tick0;
      sb.push_back(e);
    end
    for (int k = 3; k <= 11; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL reload_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      if (k == 5) begin
        total++; if (bus0.cur_div !== 8'd3) begin bad++; $display("FAIL reload_applied got=%0d exp=3", bus0.cur_div); end
        total++; if (bus0.div_pending !== 1'b0) begin bad++; $display("FAIL reload_pending_clr got=%0b exp=0", bus0.div_pending); end
      end
    end
    div_in = 8'd0; div_wr = 1'b1;
    cyc();
    div_wr = 1'b0;
    total++; if (bus0.div_pending !== 1'b1) begin bad++; $display("FAIL reload_zero_pending got=%0b exp=1", bus0.div_pending); end
    for (int k = 13; k <= 18; k++) begin
      e = '{tick0: (k == 14 || k == 16 || k == 18), tick1: 1'b0, sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 13; k <= 18; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL reload_zero_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      if (k == 14) begin
        total++; if (bus0.cur_div !== 8'd2) begin bad++; $display("FAIL reload_clamp got=%0d exp=2", bus0.cur_div); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    en = 1'b1;
    cyc();
    div_in = 8'd3; div_wr = 1'b1;
    cyc();
    div_in = 8'd6;
    cyc();
    div_wr = 1'b0;
    cyc(); cyc();
    total++; if (bus0.tick !== 1'b1) begin bad++; $display("FAIL b2b_tick5 got=%0b exp=1", bus0.tick); end
    total++; if (bus0.cur_div !== 8'd6) begin bad++; $display("FAIL b2b_last_wins got=%0d exp=6", bus0.cur_div); end
    for (int k = 6; k <= 17; k++) begin
      e = '{tick0: (k == 11 || k == 17), tick1: 1'b0, sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 6; k <= 17; k++) begin
      if (k == 11) begin div_in = 8'd4; div_wr = 1'b1; end
      cyc();
      div_wr = 1'b0;
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL b2b_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      if (k == 11) begin
        total++; if (bus0.cur_div !== 8'd6) begin bad++; $display("FAIL b2b_wrap_stage_div got=%0d exp=6", bus0.cur_div); end
        total++; if (bus0.div_pending !== 1'b1) begin bad++; $display("FAIL b2b_wrap_stage_pend got=%0b exp=1", bus0.div_pending); end
      end
      if (k == 17) begin
        total++; if (bus0.cur_div !== 8'd4) begin bad++; $display("FAIL b2b_next_apply got=%0d exp=4", bus0.cur_div); end
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    do_reset();
    en = 1'b1;
    cyc(); cyc(); cyc();
    en = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      e = '{tick0: 1'b0, tick1: 1'b0, sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 4; k <= 10; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL dis_tick0 cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      total++; if (bus1.tick !== e.tick1) begin bad++; $display("FAIL dis_tick1 cyc=%0d got=%0b exp=%0b", k, bus1.tick, e.tick1); end
    end
    total++; if (bus0.square !== 1'b1) begin bad++; $display("FAIL dis_square_clear got=%0b exp=1", bus0.square); end
    total++; if (bus1.square !== 1'b0) begin bad++; $display("FAIL dis_square_hold got=%0b exp=0", bus1.square); end
    en = 1'b1;
    for (int k = 11; k <= 17; k++) begin
      e = '{tick0: (k == 15), tick1: (k == 12 || k == 17), sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 11; k <= 17; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL reen_tick_clear cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      total++; if (bus1.tick !== e.tick1) begin bad++; $display("FAIL reen_tick_hold cyc=%0d got=%0b exp=%0b", k, bus1.tick, e.tick1); end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      e = '{tick0: (k == 5), tick1: (k == 5), sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL clr_pre_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
    end
    div_in = 8'd7; div_wr = 1'b1;
    cyc();
    div_wr = 1'b0;
    total++; if (bus0.div_pending !== 1'b1) begin bad++; $display("FAIL clr_pre_pending got=%0b exp=1", bus0.div_pending); end
    total++; if (bus0.casc_val !== 2'd1) begin bad++; $display("FAIL clr_pre_casc got=%0d exp=1", bus0.casc_val); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++; if (bus0.casc_val !== 2'd0) begin bad++; $display("FAIL clr_casc got=%0d exp=0", bus0.casc_val); end
    total++; if (bus0.cur_div !== 8'd7) begin bad++; $display("FAIL clr_cur_div got=%0d exp=7", bus0.cur_div); end
    total++; if (bus0.div_pending !== 1'b0) begin bad++; $display("FAIL clr_pending got=%0b exp=0", bus0.div_pending); end
    total++; if (bus0.tick !== 1'b0) begin bad++; $display("FAIL clr_tick got=%0b exp=0", bus0.tick); end
    total++; if (bus0.casc_carry !== 1'b0) begin bad++; $display("FAIL clr_carry got=%0b exp=0", bus0.casc_carry); end
    for (int k = 1; k <= 7; k++) begin
      e = '{tick0: (k == 7), tick1: (k == 7), sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 1; k <= 7; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL clr_post_tick0 cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
      total++; if (bus1.tick !== e.tick1) begin bad++; $display("FAIL clr_post_tick1 cyc=%0d got=%0b exp=%0b", k, bus1.tick, e.tick1); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 7; k++) cyc();
    div_in = 8'd9; div_wr = 1'b1;
    cyc();
    div_wr = 1'b0;
    total++; if (bus0.div_pending !== 1'b1) begin bad++; $display("FAIL rstm_pre_pending got=%0b exp=1", bus0.div_pending); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (bus0.tick !== 1'b0) begin bad++; $display("FAIL rstm_tick got=%0b exp=0", bus0.tick); end
    total++; if (bus0.square !== 1'b1) begin bad++; $display("FAIL rstm_square got=%0b exp=1", bus0.square); end
    total++; if (bus0.casc_val !== 2'd0) begin bad++; $display("FAIL rstm_casc got=%0d exp=0", bus0.casc_val); end
    total++; if (bus0.cur_div !== 8'd5) begin bad++; $display("FAIL rstm_cur_div got=%0d exp=5", bus0.cur_div); end
    total++; if (bus0.div_pending !== 1'b0) begin bad++; $display("FAIL rstm_pending got=%0b exp=0", bus0.div_pending); end
    for (int k = 1; k <= 6; k++) begin
      e = '{tick0: (k == 5), tick1: (k == 5), sq0: 1'b0, casc: '0, carry: 1'b0, full: 1'b0};
      sb.push_back(e);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      e = sb.pop_front();
      total++; if (bus0.tick !== e.tick0) begin bad++; $display("FAIL rstm_post_tick cyc=%0d got=%0b exp=%0b", k, bus0.tick, e.tick0); end
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_cascade();
    test_reload();
    test_back_to_back();
    test_disable();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
